// File: rtl/arith_issue_ctrl.sv
//------------------------------------------------------------------------------
// arith_issue_ctrl : queues arithmetic commands, issues them to Arithmetic_Unit,
// returns results in order. Option macro: ARITH_ISSUE_DIVZERO_CHK_EN. Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module arith_issue_ctrl #(
  parameter int OPCODE_L   = 2,
  parameter int OPERAND_L  = 32,
  parameter int RES_L      = 32,
  parameter int AU_LATENCY = 1,
  parameter int DEPTH      = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [OPCODE_L-1:0]  cmd_opcode,
  input  logic [OPERAND_L-1:0] cmd_op1,
  input  logic [OPERAND_L-1:0] cmd_op2,
  output logic [OPCODE_L-1:0]  au_opcode,
  output logic [OPERAND_L-1:0] au_operand1,
  output logic [OPERAND_L-1:0] au_operand2,
  input  logic [RES_L-1:0]     au_result,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [RES_L-1:0]     rsp_result,
  output logic [OPCODE_L-1:0]  rsp_opcode,
  output logic                 rsp_err,
  output logic                 busy
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int LW = $clog2(AU_LATENCY + 1);
  localparam logic [CW-1:0]       C_DEPTH  = CW'(DEPTH);
  localparam logic [LW-1:0]       C_LAT    = LW'(AU_LATENCY);
  localparam logic [OPCODE_L-1:0] C_OP_DIV = {OPCODE_L{1'b1}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t r_state, w_next;

  logic [OPCODE_L-1:0]  r_mem_op [DEPTH];
  logic [OPERAND_L-1:0] r_mem_a  [DEPTH];
  logic [OPERAND_L-1:0] r_mem_b  [DEPTH];
  logic [AW-1:0]        r_wptr, r_rptr;
  logic [CW-1:0]        r_count;
  logic [LW-1:0]        r_cnt;

  logic [OPCODE_L-1:0]  r_au_opcode;
  logic [OPERAND_L-1:0] r_au_op1, r_au_op2;
  logic [RES_L-1:0]     r_rsp_result;
  logic [OPCODE_L-1:0]  r_rsp_opcode;

  logic                 w_push, w_pop, w_issue, w_capture;
  logic                 w_empty, w_full, w_head_dz;
  logic [OPCODE_L-1:0]  w_head_op;
  logic [OPERAND_L-1:0] w_head_a, w_head_b;

  assign w_empty   = (r_count == '0);
  assign w_full    = (r_count == C_DEPTH);
  // Ready depends only on occupancy, never on a same-cycle pop.
  assign cmd_ready = ~rst & ~w_full;
  assign w_push    = cmd_valid & cmd_ready;

  assign w_head_op = r_mem_op[r_rptr];
  assign w_head_a  = r_mem_a[r_rptr];
  assign w_head_b  = r_mem_b[r_rptr];

`ifdef ARITH_ISSUE_DIVZERO_CHK_EN
  logic r_rsp_err;
  assign w_head_dz = (w_head_op == C_OP_DIV) && (w_head_b == '0);
  assign rsp_err   = r_rsp_err;
`else
  assign w_head_dz = 1'b0;
  assign rsp_err   = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_op[r_wptr] <= cmd_opcode;
      r_mem_a[r_wptr]  <= cmd_op1;
      r_mem_b[r_wptr]  <= cmd_op2;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    w_pop     = 1'b0;
    w_issue   = 1'b0;
    w_capture = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!w_empty) begin
          w_pop   = 1'b1;
          w_issue = ~w_head_dz;
          w_next  = w_head_dz ? S_RESP : S_WAIT;
        end
      end
      S_WAIT: begin
        if (r_cnt == C_LAT) begin
          w_capture = 1'b1;
          w_next    = S_RESP;
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          if (!w_empty) begin
            w_pop   = 1'b1;
            w_issue = ~w_head_dz;
            w_next  = w_head_dz ? S_RESP : S_WAIT;
          end else begin
            w_next = S_IDLE;
          end
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_au_opcode  <= '0;
      r_au_op1     <= '0;
      r_au_op2     <= '0;
      r_cnt        <= '0;
      r_rsp_result <= '0;
      r_rsp_opcode <= '0;
`ifdef ARITH_ISSUE_DIVZERO_CHK_EN
      r_rsp_err    <= 1'b0;
`endif
    end else begin
      if (w_issue) begin
        r_au_opcode <= w_head_op;
        r_au_op1    <= w_head_a;
        r_au_op2    <= w_head_b;
        r_cnt       <= LW'(1);
      end else if (r_state == S_WAIT && !w_capture) begin
        r_cnt <= r_cnt + LW'(1);
      end
      if (w_capture) begin
        r_rsp_result <= au_result;
        r_rsp_opcode <= r_au_opcode;
`ifdef ARITH_ISSUE_DIVZERO_CHK_EN
        r_rsp_err    <= 1'b0;
`endif
      end
`ifdef ARITH_ISSUE_DIVZERO_CHK_EN
      // Divide-by-zero is answered locally; the unit never sees it.
      if (w_pop && w_head_dz) begin
        r_rsp_result <= '1;
        r_rsp_opcode <= C_OP_DIV;
        r_rsp_err    <= 1'b1;
      end
`endif
    end
  end

  assign au_opcode   = r_au_opcode;
  assign au_operand1 = r_au_op1;
  assign au_operand2 = r_au_op2;
  assign rsp_valid   = (r_state == S_RESP);
  assign rsp_result  = r_rsp_result;
  assign rsp_opcode  = r_rsp_opcode;
  assign busy        = (r_state != S_IDLE) || !w_empty;

endmodule

`default_nettype wire

// File: tb/tb_arith_issue_ctrl.sv
//------------------------------------------------------------------------------
// tb_arith_issue_ctrl : directed + random checks of arith_issue_ctrl against a
// command-level reference model. Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_arith_issue_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [1:0]  cmd_opcode = '0;
  logic [31:0] cmd_op1 = '0;
  logic [31:0] cmd_op2 = '0;
  logic [1:0]  au_opcode;
  logic [31:0] au_operand1, au_operand2;
  logic [31:0] au_result;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_result;
  logic [1:0]  rsp_opcode;
  logic        rsp_err;
  logic        busy;

  int n_cmp = 0;
  int n_err = 0;
  int n_rsp = 0;
  int n_acc = 0;

  typedef struct {
    logic [31:0] res;
    logic [1:0]  op;
    logic        err;
  } rsp_t;

  rsp_t exp_q[$];

  arith_issue_ctrl dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_opcode(cmd_opcode), .cmd_op1(cmd_op1), .cmd_op2(cmd_op2),
    .au_opcode(au_opcode), .au_operand1(au_operand1), .au_operand2(au_operand2),
    .au_result(au_result),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_opcode(rsp_opcode), .rsp_err(rsp_err),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // Stand-in for Arithmetic_Unit: result settles before the capture edge.
  always_comb begin
    case (au_opcode)
      2'd0:    au_result = au_operand1 + au_operand2;
      2'd1:    au_result = au_operand1 - au_operand2;
      2'd2:    au_result = au_operand1 * au_operand2;
      default: au_result = (au_operand2 == 0) ? 32'd0 : au_operand1 / au_operand2;
    endcase
  end

  function automatic rsp_t ref_rsp(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    rsp_t r;
    r.op  = op;
    r.err = 1'b0;
    case (op)
      2'd0:    r.res = a + b;
      2'd1:    r.res = a - b;
      2'd2:    r.res = a * b;
      default: begin
        if (b == 0) begin
`ifdef ARITH_ISSUE_DIVZERO_CHK_EN
          r.res = 32'hFFFF_FFFF;
          r.err = 1'b1;
`else
          r.res = 32'd0;
`endif
        end else begin
          r.res = a / b;
        end
      end
    endcase
    return r;
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Scoreboard: records accepted commands, checks every response handshake.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
    end else begin
      if (cmd_valid && cmd_ready) begin
        exp_q.push_back(ref_rsp(cmd_opcode, cmd_op1, cmd_op2));
        n_acc++;
      end
      if (rsp_valid && rsp_ready) begin
        n_rsp++;
        check("rsp_expected", 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) begin
          rsp_t e;
          e = exp_q.pop_front();
          check("rsp_result", 64'(rsp_result), 64'(e.res));
          check("rsp_opcode", 64'(rsp_opcode), 64'(e.op));
          check("rsp_err", 64'(rsp_err), 64'(e.err));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    logic ok;
    ok = 1'b0;
    cmd_opcode = op;
    cmd_op1    = a;
    cmd_op2    = b;
    cmd_valid  = 1'b1;
    for (int i = 0; i < 50 && !ok; i++) begin
      ok = cmd_ready;
      tick();
    end
    cmd_valid = 1'b0;
    check("send_accepted", 64'(ok), 64'd1);
  endtask

  task automatic wait_rsp();
    for (int i = 0; i < 50 && !rsp_valid; i++) tick();
    check("wait_rsp", 64'(rsp_valid), 64'd1);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 500 && busy; i++) tick();
    check("wait_idle", 64'(busy), 64'd0);
  endtask

  initial begin
    logic [31:0] s_res, s_a, s_b;
    logic [1:0]  s_op, s_aop;
    int          seen;

    // Reset
    tick();
    check("rst_cmd_ready", 64'(cmd_ready), 64'd0);
    tick();
    rst = 1'b0;
    #1;
    check("rst_cmd_ready_rel", 64'(cmd_ready), 64'd1);
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_au", {30'd0, au_opcode, au_operand1}, 64'd0);
    check("rst_au_op2", 64'(au_operand2), 64'd0);
    check("rst_rsp_fields", {29'd0, rsp_err, rsp_opcode, rsp_result}, 64'd0);
    check("rst_busy", 64'(busy), 64'd0);

    // Single ADD latency
    rsp_ready = 1'b1;
    cmd_opcode = 2'd0; cmd_op1 = 32'd20; cmd_op2 = 32'd20; cmd_valid = 1'b1;
    tick();                                   // edge E
    cmd_valid = 1'b0;
    check("lat_E_valid", 64'(rsp_valid), 64'd0);
    check("lat_E_au", 64'(au_operand1), 64'd0);
    tick();                                   // E+1
    check("lat_E1_valid", 64'(rsp_valid), 64'd0);
    check("lat_E1_au", 64'(au_operand1), 64'd20);
    tick();                                   // E+2
    check("lat_E2_valid", 64'(rsp_valid), 64'd1);
    check("lat_E2_result", 64'(rsp_result), 64'd40);
    check("lat_E2_opcode", 64'(rsp_opcode), 64'd0);
    tick();                                   // E+3
    check("lat_E3_valid", 64'(rsp_valid), 64'd0);
    check("lat_E3_busy", 64'(busy), 64'd0);

    // Capacity: five accepted with responses stalled, sixth refused
    rsp_ready = 1'b0;
    seen = n_rsp;
    for (int i = 0; i < 5; i++) begin
      cmd_opcode = (i < 4) ? 2'(i) : 2'd0;
      cmd_op1    = (i < 4) ? 32'd20 : 32'd1;
      cmd_op2    = (i < 4) ? 32'd20 : 32'd2;
      cmd_valid  = 1'b1;
      check("fill_ready", 64'(cmd_ready), 64'd1);
      tick();
    end
    cmd_opcode = 2'd0; cmd_op1 = 32'd3; cmd_op2 = 32'd4;
    for (int i = 0; i < 3; i++) begin
      check("full_ready", 64'(cmd_ready), 64'd0);
      tick();
    end
    rsp_ready = 1'b1;
    for (int i = 0; i < 50 && !cmd_ready; i++) tick();
    check("sixth_ready", 64'(cmd_ready), 64'd1);
    tick();
    cmd_valid = 1'b0;
    wait_idle();
    tick();
    check("fill_rsp_count", 64'(n_rsp - seen), 64'd6);

    // Backpressure holds outputs
    rsp_ready = 1'b0;
    send(2'd2, $urandom, $urandom);
    wait_rsp();
    s_res = rsp_result; s_op = rsp_opcode;
    s_aop = au_opcode; s_a = au_operand1; s_b = au_operand2;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("bp_valid", 64'(rsp_valid), 64'd1);
      check("bp_rsp", {30'd0, rsp_opcode, rsp_result}, {30'd0, s_op, s_res});
      check("bp_au", {au_opcode, au_operand1, au_operand2[29:0]}, {s_aop, s_a, s_b[29:0]});
    end
    rsp_ready = 1'b1;
    tick();
    check("bp_taken", 64'(rsp_valid), 64'd0);
    wait_idle();

    // Divide by zero
    rsp_ready = 1'b0;
    s_aop = au_opcode; s_a = au_operand1; s_b = au_operand2;
    send(2'd3, 32'd20, 32'd0);
    wait_rsp();
    check("dz_opcode", 64'(rsp_opcode), 64'd3);
`ifdef ARITH_ISSUE_DIVZERO_CHK_EN
    check("dz_err", 64'(rsp_err), 64'd1);
    check("dz_result", 64'(rsp_result), 64'hFFFF_FFFF);
    check("dz_au", {au_opcode, au_operand1, au_operand2[29:0]}, {s_aop, s_a, s_b[29:0]});
`else
    check("dz_err", 64'(rsp_err), 64'd0);
    check("dz_result", 64'(rsp_result), 64'(au_result));
    check("dz_au", {30'd0, au_opcode, au_operand2}, {30'd0, 2'd3, 32'd0});
`endif
    rsp_ready = 1'b1;
    tick();
    wait_idle();

    // Randomized traffic
    seen = n_acc;
    for (int c = 0; c < 3000 && (n_acc - seen) < 60; c++) begin
      cmd_valid  = ($urandom_range(0, 3) != 0);
      cmd_opcode = 2'($urandom_range(0, 3));
      cmd_op1    = ($urandom_range(0, 1) != 0) ? $urandom : 32'($urandom_range(0, 100));
      cmd_op2    = ($urandom_range(0, 5) == 0) ? 32'd0 : 32'($urandom_range(1, 1000));
      rsp_ready  = ($urandom_range(0, 2) != 0);
      tick();
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    check("rand_accepted", 64'(n_acc - seen >= 60), 64'd1);
    wait_idle();
    tick();
    check("rand_drained", 64'(exp_q.size()), 64'd0);

    // Reset while WAIT with three queued
    rsp_ready = 1'b0;
    for (int i = 0; i < 5; i++) send(2'd0, 32'(i), 32'd10);
    check("rstmid_full", 64'(cmd_ready), 64'd0);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check("rstmid_wait", {62'd0, rsp_valid, busy}, 64'd1);
    rst = 1'b1;
    #1;
    check("rstmid_valid", 64'(rsp_valid), 64'd0);
    check("rstmid_busy", 64'(busy), 64'd0);
    tick();
    tick();
    rst = 1'b0;
    rsp_ready = 1'b1;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (rsp_valid) seen++;
    end
    check("rstmid_no_rsp", 64'(seen), 64'd0);
    check("rstmid_idle", 64'(busy), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
